updown_count_ctrl: RTL and testbench

UPDOWN_COUNT_CTRL -- requirements
Module: updown_count_ctrl

---
 rtl/updown_ctrl_pkg.sv | 28 ++
 rtl/updown_count_ctrl_step_core.sv | 34 +++
 rtl/updown_count_ctrl.sv | 163 ++++++++++++++++
 tb/tb_updown_count_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/updown_ctrl_pkg.sv
// updown_ctrl_pkg
//   Shared definitions for the up/down count controller slice:
//     - state_t   : controller FSM state encoding (IDLE, RUN, DONE)
//     - CNT_W     : count width
//     - CNT_ONE   : unit step at count width
//     - end_limit : limit at which a run in the given direction stops
package updown_ctrl_pkg;

    localparam int CNT_W = 4;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // An up-count finishes at hi, a down-count finishes at lo.
    function automatic logic [CNT_W-1:0] end_limit(
        input logic             up,
        input logic [CNT_W-1:0] lo,
        input logic [CNT_W-1:0] hi
    );
        end_limit = up ? hi : lo;
    endfunction

endpackage

// File: rtl/updown_count_ctrl_step_core.sv
// ud_step_core
//   Count register with synchronous load and a +/-1 step.
//   Ports:
//     clk      : rising-edge clock
//     rst      : asynchronous active-high reset, clears q
//     load     : load load_val on the next edge (wins over en)
//     en       : step q by one on the next edge
//     up       : step direction, 1 = +1, 0 = -1
//     load_val : value to load
//     q        : current count
module ud_step_core
    import updown_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic             up,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= load_val;
        end else if (en) begin
            // Wraps modulo 2^CNT_W; the controller never asks for a step past a limit.
            q <= up ? (q + CNT_ONE) : (q - CNT_ONE);
        end
    end

endmodule

// File: rtl/updown_count_ctrl.sv
// updown_count_ctrl
//   Runs a counter from one limit to the other, optionally bouncing between
//   the limits (ping-pong) until stopped.
//   Build option: define UPDOWN_CTRL_PINGPONG_EN to enable ping-pong; when it
//   is undefined pp_mode is ignored and every run ends in DONE.
//   Ports:
//     clk       : rising-edge clock
//     rst       : asynchronous active-high reset
//     start     : begin a run (only looked at in IDLE)
//     stop      : abort a run / ping-pong; beats start in IDLE
//     dir_up    : 1 = count lo->hi, 0 = hi->lo (captured at start)
//     lo, hi    : count limits (captured at start, lo must be <= hi)
//     pp_mode   : ping-pong request (captured at start)
//     q         : current count
//     busy      : high while in RUN
//     done      : one-cycle pulse on normal completion
//     err       : one-cycle pulse when a start is rejected (lo > hi)
//     dir_o     : current count direction (1 = up)
//     state_dbg : current FSM state encoding
//   start/stop are level-sampled requests, not a handshake: a start seen in
//   IDLE with stop low is either accepted (busy rises next edge) or rejected
//   (err pulses next edge); there is no back-pressure.
module updown_count_ctrl
    import updown_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             dir_up,
    input  logic [CNT_W-1:0] lo,
    input  logic [CNT_W-1:0] hi,
    input  logic             pp_mode,
    output logic [CNT_W-1:0] q,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             dir_o,
    output logic [1:0]       state_dbg
);

    state_t           state, state_n;
    logic [CNT_W-1:0] lo_r, hi_r, lo_n, hi_n;
    logic             dir_n;
    logic             err_n;

    logic             core_load;
    logic             core_en;
    logic             core_up;
    logic [CNT_W-1:0] core_val;

    logic             at_end;
    logic             pp_active;

`ifdef UPDOWN_CTRL_PINGPONG_EN
    logic pp_r, pp_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pp_r <= 1'b0;
        end else begin
            pp_r <= pp_n;
        end
    end

    assign pp_active = pp_r;
`else
    // Ping-pong compiled out: request input intentionally left unused.
    logic unused_pp_mode;
    assign unused_pp_mode = pp_mode;
    assign pp_active      = 1'b0;
`endif

    ud_step_core u_core (
        .clk      (clk),
        .rst      (rst),
        .load     (core_load),
        .en       (core_en),
        .up       (core_up),
        .load_val (core_val),
        .q        (q)
    );

    assign at_end = (q == end_limit(dir_o, lo_r, hi_r));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            dir_o <= 1'b1;
            lo_r  <= '0;
            hi_r  <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_n;
            dir_o <= dir_n;
            lo_r  <= lo_n;
            hi_r  <= hi_n;
            err   <= err_n;
        end
    end

    always_comb begin
        state_n   = state;
        dir_n     = dir_o;
        lo_n      = lo_r;
        hi_n      = hi_r;
        err_n     = 1'b0;
        core_load = 1'b0;
        core_en   = 1'b0;
        core_up   = dir_o;
        core_val  = '0;
`ifdef UPDOWN_CTRL_PINGPONG_EN
        pp_n      = pp_r;
`endif
        unique case (state)
            IDLE: begin
                if (start && !stop) begin
                    if (lo <= hi) begin
                        state_n   = RUN;
                        dir_n     = dir_up;
                        lo_n      = lo;
                        hi_n      = hi;
                        core_load = 1'b1;
                        core_val  = dir_up ? lo : hi;
`ifdef UPDOWN_CTRL_PINGPONG_EN
                        pp_n      = pp_mode;
`endif
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            RUN: begin
                if (stop) begin
                    state_n = IDLE;
                end else if (!at_end) begin
                    core_en = 1'b1;
                    core_up = dir_o;
                end else if (pp_active) begin
                    // Bounce off the limit; a zero-width range just holds q.
                    if (lo_r != hi_r) begin
                        dir_n   = ~dir_o;
                        core_en = 1'b1;
                        core_up = ~dir_o;
                    end
                end else begin
                    state_n = DONE;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign busy      = (state == RUN);
    assign done      = (state == DONE);
    assign state_dbg = state;

endmodule

// File: tb/tb_updown_count_ctrl.sv
// tb_updown_count_ctrl
//   Directed bench for updown_count_ctrl. Inputs are driven and outputs
//   sampled 1 time unit after each rising edge.
module tb_updown_count_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic       stop;
    logic       dir_up;
    logic [3:0] lo;
    logic [3:0] hi;
    logic       pp_mode;
    logic [3:0] q;
    logic       busy;
    logic       done;
    logic       err;
    logic       dir_o;
    logic [1:0] state_dbg;

    int vectors    = 0;
    int miscompares = 0;

    logic [3:0] exp_q[$];

    updown_count_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .dir_up    (dir_up),
        .lo        (lo),
        .hi        (hi),
        .pp_mode   (pp_mode),
        .q         (q),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .dir_o     (dir_o),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] eq, input logic eb,
                           input logic ed, input logic ee);
        check({tag, ".q"},    {4'd0, q},    {4'd0, eq});
        check({tag, ".busy"}, {7'd0, busy}, {7'd0, eb});
        check({tag, ".done"}, {7'd0, done}, {7'd0, ed});
        check({tag, ".err"},  {7'd0, err},  {7'd0, ee});
    endtask

    task automatic set_run(input logic [3:0] l, input logic [3:0] h, input logic d, input logic p);
        lo = l; hi = h; dir_up = d; pp_mode = p; start = 1'b1;
    endtask

    // Scoreboard: each tick pops the next expected count of a running sequence.
    task automatic run_expect(input string tag);
        logic [3:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk_out(tag, e, 1'b1, 1'b0, 1'b0);
            tick();
            start = 1'b0;
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; dir_up = 1'b0;
        lo = 4'd0; hi = 4'd0; pp_mode = 1'b0;
        #3;
        chk_out("reset", 4'd0, 1'b0, 1'b0, 1'b0);
        check("reset.dir_o", {7'd0, dir_o}, 8'd1);
        check("reset.state", {6'd0, state_dbg}, 8'd0);
        #4 rst = 1'b0;
        tick();
        chk_out("post_reset_idle", 4'd0, 1'b0, 1'b0, 1'b0);

        // Up run 2..5; limits scrambled after start must not matter.
        set_run(4'd2, 4'd5, 1'b1, 1'b0);
        tick();
        start = 1'b0; lo = 4'd0; hi = 4'd15;
        check("up.dir_o", {7'd0, dir_o}, 8'd1);
        check("up.state", {6'd0, state_dbg}, 8'd1);
        exp_q = '{4'd2, 4'd3, 4'd4, 4'd5};
        run_expect("up");
        chk_out("up.done", 4'd5, 1'b0, 1'b1, 1'b0);
        tick();
        chk_out("up.after", 4'd5, 1'b0, 1'b0, 1'b0);

        // Down run 3..0, no wrap to 15.
        set_run(4'd0, 4'd3, 1'b0, 1'b0);
        tick();
        check("down.dir_o", {7'd0, dir_o}, 8'd0);
        exp_q = '{4'd3, 4'd2, 4'd1, 4'd0};
        run_expect("down");
        chk_out("down.done", 4'd0, 1'b0, 1'b1, 1'b0);
        tick();
        chk_out("down.after", 4'd0, 1'b0, 1'b0, 1'b0);

        // Rejected start: lo > hi.
        set_run(4'd9, 4'd4, 1'b1, 1'b0);
        tick();
        start = 1'b0;
        chk_out("reject", 4'd0, 1'b0, 1'b0, 1'b1);
        tick();
        chk_out("reject.after", 4'd0, 1'b0, 1'b0, 1'b0);

        // lo == hi: one RUN cycle then DONE.
        set_run(4'd6, 4'd6, 1'b1, 1'b0);
        tick();
        start = 1'b0;
        chk_out("equal.run", 4'd6, 1'b1, 1'b0, 1'b0);
        tick();
        chk_out("equal.done", 4'd6, 1'b0, 1'b1, 1'b0);
        tick();
        chk_out("equal.after", 4'd6, 1'b0, 1'b0, 1'b0);

        // start held high through RUN: no restart.
        set_run(4'd1, 4'd3, 1'b1, 1'b0);
        tick();
        for (int k = 1; k <= 3; k++) begin
            chk_out("hold_start", 4'(k), 1'b1, 1'b0, 1'b0);
            tick();
        end
        chk_out("hold_start.done", 4'd3, 1'b0, 1'b1, 1'b0);
        start = 1'b0;
        tick();
        chk_out("hold_start.after", 4'd3, 1'b0, 1'b0, 1'b0);

        // start + stop together in IDLE: stop wins.
        set_run(4'd0, 4'd5, 1'b1, 1'b0);
        stop = 1'b1;
        tick();
        chk_out("start_stop", 4'd3, 1'b0, 1'b0, 1'b0);
        start = 1'b0; stop = 1'b0;
        tick();
        chk_out("start_stop.after", 4'd3, 1'b0, 1'b0, 1'b0);

        // Stop mid-run: IDLE, q held, no done pulse.
        set_run(4'd4, 4'd8, 1'b1, 1'b0);
        tick();
        start = 1'b0;
        chk_out("stop.run", 4'd4, 1'b1, 1'b0, 1'b0);
        tick();
        chk_out("stop.run2", 4'd5, 1'b1, 1'b0, 1'b0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk_out("stop.idle", 4'd5, 1'b0, 1'b0, 1'b0);
        tick();
        chk_out("stop.after", 4'd5, 1'b0, 1'b0, 1'b0);

`ifdef UPDOWN_CTRL_PINGPONG_EN
        // Ping-pong 1..3: 1,2,3,2,1,2 then stop at 2.
        set_run(4'd1, 4'd3, 1'b1, 1'b1);
        tick();
        exp_q = '{4'd1, 4'd2, 4'd3, 4'd2, 4'd1, 4'd2};
        run_expect("pp");
        // Last pop ticked once more past the final 2: count is now 3 going up.
        chk_out("pp.cont", 4'd3, 1'b1, 1'b0, 1'b0);
        tick();
        chk_out("pp.bounce", 4'd2, 1'b1, 1'b0, 1'b0);
        check("pp.dir_o", {7'd0, dir_o}, 8'd0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk_out("pp.stop", 4'd2, 1'b0, 1'b0, 1'b0);

        // Ping-pong with lo == hi: holds in RUN until stopped.
        set_run(4'd7, 4'd7, 1'b0, 1'b1);
        tick();
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk_out("pp_eq", 4'd7, 1'b1, 1'b0, 1'b0);
            tick();
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk_out("pp_eq.stop", 4'd7, 1'b0, 1'b0, 1'b0);
`else
        // Ping-pong compiled out: pp_mode ignored, run ends in DONE.
        set_run(4'd1, 4'd2, 1'b1, 1'b1);
        tick();
        exp_q = '{4'd1, 4'd2};
        run_expect("pp_off");
        chk_out("pp_off.done", 4'd2, 1'b0, 1'b1, 1'b0);
        tick();
        chk_out("pp_off.after", 4'd2, 1'b0, 1'b0, 1'b0);
`endif

        // Reset mid-run at q=7: immediate, no clock edge needed.
        set_run(4'd0, 4'd15, 1'b1, 1'b0);
        tick();
        start = 1'b0;
        repeat (7) tick();
        chk_out("rst_mid.pre", 4'd7, 1'b1, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk_out("rst_mid", 4'd0, 1'b0, 1'b0, 1'b0);
        check("rst_mid.dir_o", {7'd0, dir_o}, 8'd1);
        #2 rst = 1'b0;
        tick();
        chk_out("rst_mid.after", 4'd0, 1'b0, 1'b0, 1'b0);

        // First start after reset is accepted normally.
        set_run(4'd3, 4'd3, 1'b0, 1'b0);
        tick();
        start = 1'b0;
        chk_out("post_rst_run", 4'd3, 1'b1, 1'b0, 1'b0);
        check("post_rst_run.dir_o", {7'd0, dir_o}, 8'd0);
        tick();
        chk_out("post_rst_run.done", 4'd3, 1'b0, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
